timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Control sequencer for the minute/second countdown display timer. It holds the user-set minute preset and loads it into the timer. It then generates the timer's count-enable tick from the system clock and handles start, pause, resume and expiry. On expiry it drives an alarm, and it sits between the front-panel buttons and the countdown timer.

## Interface
Parameters:
- TICK_DIV, 50: clock cycles per timer tick; t_open pulses once per TICK_DIV cycles; must be ≥2
- MAX_MIN, 99: upper limit of preset; must be ≤127
- DEF_MIN, 10: preset value after reset; must be in 1..MAX_MIN
- ALARM_LEN, 8: alarm duration in ticks; must be ≥1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- btn_start  in  1  start/resume/acknowledge button, level; rising edge detected internally
- btn_pause  in  1  pause/resume button, level; rising edge detected internally
- btn_up  in  1  preset increment, level; rising edge detected internally
- btn_down  in  1  preset decrement, level; rising edge detected internally
- t_stop  in  1  timer expired flag from countdown timer
- preset  out  7  minute value driven to the timer's load input
- t_rst  out  1  active-low load/reset to timer
- t_open  out  1  one-cycle count-enable tick to timer
- alarm  out  1  expiry alarm
- state  out  3  current state: IDLE=0, LOAD=1, RUN=2, PAUSE=3, ALARM=4

## Operation
- All outputs are registered. Reset values: state=IDLE, preset=DEF_MIN, t_rst=0, t_open=0, alarm=0, prescaler=0, tick counter=0.
- Edge detect: the previous-value register for each button resets to 1, so a button held through reset produces no edge. edge = btn & ~prev.
- IDLE: t_rst=1, t_open=0.
  - up edge: preset+1, saturating at MAX_MIN.
  - down edge: preset-1, saturating at 1.
  - up and down in the same cycle: no change.
  - start edge: go to LOAD. If start and up/down edges coincide, start wins and preset is unchanged.
  - pause edge: ignored.
- LOAD: lasts exactly one cycle with t_rst=0, then go to RUN. Prescaler clears.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps. t_open=1 in the cycle after the prescaler reaches TICK_DIV-1, so it is 1 for one cycle per TICK_DIV.
  - pause edge: go to PAUSE.
  - start, up and down edges: ignored.
  - t_stop=1: go to ALARM. t_stop is ignored during the first RUN cycle after LOAD, because the timer's stop flag clears on that edge.
  - If pause and t_stop coincide, t_stop wins.
- PAUSE: prescaler holds its value and t_open=0. A start edge or a pause edge returns to RUN, and the prescaler resumes from the held value.
- ALARM:
  - alarm=1 and t_open=0. The prescaler keeps running, and each wrap increments the tick counter.
  - When the tick counter reaches ALARM_LEN, go to IDLE and clear alarm and the tick counter.
  - start edge: go to IDLE immediately (acknowledge).
  - Other edges: ignored.
  - t_stop stays high from the timer and is ignored outside RUN.
- Reset mid-operation: at any state, rst=0 on a clock edge forces the reset values. t_rst is 0 during reset so the timer reloads preset=DEF_MIN.
- Prescaler width is ceil(log2(TICK_DIV)). Tick counter width is ceil(log2(ALARM_LEN+1)).

## Timing
- A button edge sampled at edge n produces a state or preset change visible after edge n.
- start edge in IDLE: state=LOAD and t_rst=0 for exactly one cycle, then state=RUN.
- First t_open comes TICK_DIV cycles after entering RUN. After that, t_open pulses every TICK_DIV cycles.
- Pause then resume: the next t_open arrives after the remaining prescaler count. No tick is lost or duplicated.
- t_stop sampled high at edge n in RUN: state=ALARM and alarm=1 after edge n. No t_open is issued in that cycle.
- ALARM lasts ALARM_LEN×TICK_DIV cycles, within one cycle depending on the prescaler phase at entry.

## Test plan
- Reset with btn_up held high, then release rst: preset=10, state=0, t_rst goes 1 the cycle after release, and no spurious increment.
- 3 up edges, then 20 down edges: preset goes 13 and then saturates at 1. 200 up edges: preset saturates at 99. Simultaneous up+down: preset unchanged.
- start edge with TICK_DIV=4: t_rst low for exactly 1 cycle, then t_open pulses every 4th cycle, and up/down are ignored in RUN.
- Pause after 2 prescaler counts, hold 10 cycles, then resume with start: no t_open while paused, and the next t_open arrives 2 cycles after resume.
- Assert t_stop in RUN with ALARM_LEN=2, TICK_DIV=4: alarm=1 for 8±1 cycles, then state=IDLE. Repeat with a start edge during the alarm: IDLE on the next cycle.
- Assert rst in RUN and in ALARM: all outputs return to their reset values on the next edge, and t_open and alarm are 0.

Source files
------------

// File: rtl/timer_ctrl.sv
// Control sequencer for the minute/second countdown timer: preset entry,
// load pulse, count-enable tick generation, pause/resume and expiry alarm.
module timer_ctrl #(
  parameter int TICK_DIV  = 50,
  parameter int MAX_MIN   = 99,
  parameter int DEF_MIN   = 10,
  parameter int ALARM_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       t_stop,
  output logic [6:0] preset,
  output logic       t_rst,
  output logic       t_open,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(ALARM_LEN + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TICK_LAST  = CW'(ALARM_LEN - 1);
  localparam logic [6:0]    PRESET_MAX = 7'(MAX_MIN);
  localparam logic [6:0]    PRESET_DEF = 7'(DEF_MIN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      preset_q, preset_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic            t_rst_q, t_open_q, t_open_d, alarm_q;
  logic            first_run_q;
  logic [3:0]      btn_prev_q;

  logic [3:0]      btn_now, btn_edge;
  logic            start_e, pause_e, up_e, down_e;
  logic            presc_wrap;
  logic [PW-1:0]   presc_inc;

  assign btn_now  = {btn_start, btn_pause, btn_up, btn_down};
  assign btn_edge = btn_now & ~btn_prev_q;
  assign {start_e, pause_e, up_e, down_e} = btn_edge;

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign presc_inc  = presc_wrap ? '0 : presc_q + PW'(1);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    preset_d = preset_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    t_open_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_e) begin
          state_d = LOAD;
        end else if (up_e && !down_e) begin
          if (preset_q < PRESET_MAX) preset_d = preset_q + 7'd1;
        end else if (down_e && !up_e) begin
          if (preset_q > 7'd1) preset_d = preset_q - 7'd1;
        end
      end
      LOAD: begin
        state_d = RUN;
        presc_d = '0;
      end
      RUN: begin
        // The timer's stop flag is still stale on the first cycle after a load.
        if (t_stop && !first_run_q) begin
          state_d = ALARM;
          presc_d = presc_inc;
          tick_d  = '0;
        end else if (pause_e) begin
          state_d = PAUSE;
        end else begin
          presc_d  = presc_inc;
          t_open_d = presc_wrap;
        end
      end
      PAUSE: begin
        if (start_e || pause_e) state_d = RUN;
      end
      ALARM: begin
        if (start_e) begin
          state_d = IDLE;
          tick_d  = '0;
        end else begin
          presc_d = presc_inc;
          if (presc_wrap) begin
            if (tick_q == TICK_LAST) begin
              state_d = IDLE;
              tick_d  = '0;
            end else begin
              tick_d = tick_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      preset_q    <= PRESET_DEF;
      presc_q     <= '0;
      tick_q      <= '0;
      t_rst_q     <= 1'b0;
      t_open_q    <= 1'b0;
      alarm_q     <= 1'b0;
      first_run_q <= 1'b0;
      // Buttons held through reset must not register as a press.
      btn_prev_q  <= '1;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q     <= state_d;
      preset_q    <= preset_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      t_rst_q     <= (state_d != LOAD);
      t_open_q    <= t_open_d;
      alarm_q     <= (state_d == ALARM);
      first_run_q <= (state_q == LOAD);
      btn_prev_q  <= btn_now;
    end
  end

  assign state  = state_q;
  assign preset = preset_q;
  assign t_rst  = t_rst_q;
  assign t_open = t_open_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expected values go into a scoreboard queue
// as stimulus is applied and are popped when the outputs are sampled.
module tb_timer_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int MAX_MIN   = 99;
  localparam int DEF_MIN   = 10;
  localparam int ALARM_LEN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       t_stop = 1'b0;
  logic [6:0] preset;
  logic       t_rst, t_open, alarm;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb_q[$];

  timer_ctrl #(
    .TICK_DIV (TICK_DIV),
    .MAX_MIN  (MAX_MIN),
    .DEF_MIN  (DEF_MIN),
    .ALARM_LEN(ALARM_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .t_stop   (t_stop),
    .preset   (preset),
    .t_rst    (t_rst),
    .t_open   (t_open),
    .alarm    (alarm),
    .state    (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // Inputs change right after a falling edge; outputs are read there too.
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=queued_entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic push_outs(input string tag, input int st, input int pre,
                           input bit trst, input bit topen, input bit al);
    push({tag, "_state"},  16'(st));
    push({tag, "_preset"}, 16'(pre));
    push({tag, "_t_rst"},  16'(trst));
    push({tag, "_t_open"}, 16'(topen));
    push({tag, "_alarm"},  16'(al));
  endtask

  task automatic check_outs();
    check(16'(state));
    check(16'(preset));
    check(16'(t_rst));
    check(16'(t_open));
    check(16'(alarm));
  endtask

  // 0=start 1=pause 2=up 3=down
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_start = v;
      1: btn_pause = v;
      2: btn_up    = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    step();
    set_btn(which, 1'b0);
    step();
  endtask

  initial begin
    int cnt;
    int opens;

    // Reset with up held: no increment may appear after release.
    rst    = 1'b0;
    btn_up = 1'b1;
    step(2);
    push_outs("reset", 0, DEF_MIN, 1'b0, 1'b0, 1'b0);
    check_outs();
    rst = 1'b1;
    push_outs("release", 0, DEF_MIN, 1'b1, 1'b0, 1'b0);
    step();
    check_outs();
    push("no_spurious_up", 16'(DEF_MIN));
    step();
    check(16'(preset));
    btn_up = 1'b0;
    step();

    // Preset entry and saturation.
    repeat (3) press(2);
    push("up3", 16'd13);
    check(16'(preset));
    repeat (12) press(3);
    push("down_to_1", 16'd1);
    check(16'(preset));
    repeat (8) press(3);
    push("down_sat", 16'd1);
    check(16'(preset));
    repeat (98) press(2);
    push("up_to_max", 16'(MAX_MIN));
    check(16'(preset));
    repeat (102) press(2);
    push("up_sat", 16'(MAX_MIN));
    check(16'(preset));
    press(3);
    push("down_from_max", 16'd98);
    check(16'(preset));
    btn_up   = 1'b1;
    btn_down = 1'b1;
    step();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step();
    push("up_down_same", 16'd98);
    check(16'(preset));
    press(1);
    push("pause_in_idle", 16'd0);
    check(16'(state));

    // Start: one LOAD cycle, then RUN with a tick every TICK_DIV cycles.
    btn_start = 1'b1;
    push_outs("load", 1, 98, 1'b0, 1'b0, 1'b0);
    step();
    check_outs();
    btn_start = 1'b0;
    push_outs("run_entry", 2, 98, 1'b1, 1'b0, 1'b0);
    step();
    check_outs();
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) btn_up = 1'b1;
      if (k == 2) btn_up = 1'b0;
      if (k == 5) btn_down = 1'b1;
      if (k == 6) btn_down = 1'b0;
      push("run_t_open", 16'((k % TICK_DIV) == 0));
      step();
      check(16'(t_open));
    end
    push("run_preset_frozen", 16'd98);
    check(16'(preset));
    push("run_state", 16'd2);
    check(16'(state));

    // Pause after two prescaler counts, hold, resume with start.
    step(2);
    btn_pause = 1'b1;
    push_outs("pause", 3, 98, 1'b1, 1'b0, 1'b0);
    step();
    check_outs();
    btn_pause = 1'b0;
    opens = 0;
    repeat (10) begin
      step();
      opens += int'(t_open);
    end
    push("pause_no_t_open", 16'd0);
    check(16'(opens));
    push("pause_held", 16'd3);
    check(16'(state));
    btn_start = 1'b1;
    push("resume_state", 16'd2);
    step();
    check(16'(state));
    btn_start = 1'b0;
    push("resume_t_open_1", 16'd0);
    step();
    check(16'(t_open));
    push("resume_t_open_2", 16'd1);
    step();
    check(16'(t_open));

    // Expiry arriving on the cycle that would otherwise issue a tick.
    step(3);
    t_stop = 1'b1;
    push_outs("alarm_entry", 4, 98, 1'b1, 1'b0, 1'b1);
    step();
    check_outs();
    cnt   = 1;
    opens = 0;
    for (int i = 0; i < 30 && alarm; i++) begin
      step();
      if (alarm) cnt++;
      opens += int'(t_open);
    end
    push("alarm_cycles_7to9", 16'd1);
    check(16'(cnt >= 7 && cnt <= 9));
    push("alarm_no_t_open", 16'd0);
    check(16'(opens));
    push("alarm_done_idle", 16'd0);
    check(16'(state));
    push("t_stop_ignored_idle", 16'd0);
    step();
    check(16'(state));

    // Restart with t_stop still high: ignored on the first RUN cycle only.
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    push("first_run_ignores_t_stop", 16'd2);
    step();
    check(16'(state));
    push("t_stop_to_alarm", 16'd4);
    step();
    check(16'(state));
    step();
    btn_start = 1'b1;
    push_outs("alarm_ack", 0, 98, 1'b1, 1'b0, 1'b0);
    step();
    check_outs();
    btn_start = 1'b0;
    t_stop    = 1'b0;
    step();

    // Reset in RUN, on the cycle a tick would otherwise be issued.
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    step(3);
    rst = 1'b0;
    push_outs("rst_in_run", 0, DEF_MIN, 1'b0, 1'b0, 1'b0);
    step();
    check_outs();
    rst = 1'b1;
    step();

    // Reset in ALARM.
    t_stop    = 1'b1;
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step(3);
    push("alarm_before_rst", 16'd1);
    check(16'(alarm));
    rst = 1'b0;
    push_outs("rst_in_alarm", 0, DEF_MIN, 1'b0, 1'b0, 1'b0);
    step();
    check_outs();
    rst    = 1'b1;
    t_stop = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
